// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution loop controller.
// Related files: wrap_counter.sv, conv_loop_controller.sv.
package conv_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } ctrl_state_t;

    // A dimension of 1 still needs a 1-bit counter so ports never collapse to zero width.
    function automatic int cw(input int n);
        cw = (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int beats_per_output(input int kernel_size, input int in_channels);
        beats_per_output = kernel_size * kernel_size * in_channels;
    endfunction

    localparam int DEF_KERNEL_SIZE          = 3;
    localparam int DEF_INPUT_NB_CHANNELS    = 2;
    localparam int DEF_BEATS_PER_OUTPUT     = beats_per_output(DEF_KERNEL_SIZE, DEF_INPUT_NB_CHANNELS);

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX loop counter: advances on en, wraps to 0 after MAX-1, flags its last value.
// Chained by the controller via en & last to build nested loops.
module wrap_counter
    import conv_ctrl_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 en,
    input  logic                 clr,
    output logic [cw(MAX)-1:0]   cnt,
    output logic                 last
);

    localparam int CW = cw(MAX);
    localparam logic [CW-1:0] LAST_VAL = CW'(MAX - 1);

    logic [CW-1:0] cnt_r;

    assign cnt  = cnt_r;
    assign last = (cnt_r == LAST_VAL);

    // Counter state: clear wins over advance; wrap happens when advancing from the last value.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (last) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/conv_loop_controller.sv
// Convolution loop sequencer: walks y, x, ch_out, ch_in, ky, kx and strobes finished outputs.
// Optional stall counter port enabled by defining CONV_CTRL_STALL_CNT_EN.
module conv_loop_controller
    import conv_ctrl_pkg::*;
#(
    parameter int FEATURE_MAP_WIDTH  = 4,
    parameter int FEATURE_MAP_HEIGHT = 3,
    parameter int INPUT_NB_CHANNELS  = DEF_INPUT_NB_CHANNELS,
    parameter int OUTPUT_NB_CHANNELS = 2,
    parameter int KERNEL_SIZE        = DEF_KERNEL_SIZE
) (
    input  logic                                  clk,
    input  logic                                  arst_n,
    input  logic                                  start,
    output logic                                  running,
    input  logic                                  valid,
    output logic                                  ready,
    output logic                                  mac_en,
    output logic                                  acc_clear,
    output logic                                  output_valid,
    output logic [cw(FEATURE_MAP_WIDTH)-1:0]      output_x,
    output logic [cw(FEATURE_MAP_HEIGHT)-1:0]     output_y,
    output logic [cw(OUTPUT_NB_CHANNELS)-1:0]     output_ch,
    output logic                                  done
`ifdef CONV_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]                           stall_cycles
`endif
);

    localparam int XW  = cw(FEATURE_MAP_WIDTH);
    localparam int YW  = cw(FEATURE_MAP_HEIGHT);
    localparam int COW = cw(OUTPUT_NB_CHANNELS);
    localparam int CIW = cw(INPUT_NB_CHANNELS);
    localparam int KW  = cw(KERNEL_SIZE);

    ctrl_state_t     state_r;
    logic            running_r;
    logic            ready_r;
    logic            output_valid_r;
    logic            acc_clear_r;
    logic            done_r;
    logic [XW-1:0]   output_x_r;
    logic [YW-1:0]   output_y_r;
    logic [COW-1:0]  output_ch_r;

    logic            mac_en_s;
    logic            start_acc_s;
    logic            write_s;
    logic            beat_last_s;
    logic            layer_last_s;

    logic [KW-1:0]   kx_s;
    logic [KW-1:0]   ky_s;
    logic [CIW-1:0]  ci_s;
    logic [COW-1:0]  co_s;
    logic [XW-1:0]   x_s;
    logic [YW-1:0]   y_s;
    logic            kx_last_s;
    logic            ky_last_s;
    logic            ci_last_s;
    logic            co_last_s;
    logic            x_last_s;
    logic            y_last_s;

    // Inner tap/channel values live in the datapath's addressing; only their wrap flags matter here.
    logic            unused_inner_s;
    assign unused_inner_s = ^{kx_s, ky_s, ci_s};

    assign mac_en_s     = valid & ready_r;
    assign start_acc_s  = (state_r == IDLE) & start;
    assign write_s      = (state_r == WRITE);
    assign beat_last_s  = kx_last_s & ky_last_s & ci_last_s;
    assign layer_last_s = co_last_s & x_last_s & y_last_s;

    assign running      = running_r;
    assign ready        = ready_r;
    assign mac_en       = mac_en_s;
    assign acc_clear    = acc_clear_r;
    assign output_valid = output_valid_r;
    assign output_x     = output_x_r;
    assign output_y     = output_y_r;
    assign output_ch    = output_ch_r;
    assign done         = done_r;

    wrap_counter #(.MAX(KERNEL_SIZE)) u_kx (
        .clk(clk), .arst_n(arst_n), .en(mac_en_s), .clr(start_acc_s),
        .cnt(kx_s), .last(kx_last_s)
    );

    wrap_counter #(.MAX(KERNEL_SIZE)) u_ky (
        .clk(clk), .arst_n(arst_n), .en(mac_en_s & kx_last_s), .clr(start_acc_s),
        .cnt(ky_s), .last(ky_last_s)
    );

    wrap_counter #(.MAX(INPUT_NB_CHANNELS)) u_ci (
        .clk(clk), .arst_n(arst_n), .en(mac_en_s & kx_last_s & ky_last_s), .clr(start_acc_s),
        .cnt(ci_s), .last(ci_last_s)
    );

    wrap_counter #(.MAX(OUTPUT_NB_CHANNELS)) u_co (
        .clk(clk), .arst_n(arst_n), .en(write_s), .clr(start_acc_s),
        .cnt(co_s), .last(co_last_s)
    );

    wrap_counter #(.MAX(FEATURE_MAP_WIDTH)) u_x (
        .clk(clk), .arst_n(arst_n), .en(write_s & co_last_s), .clr(start_acc_s),
        .cnt(x_s), .last(x_last_s)
    );

    wrap_counter #(.MAX(FEATURE_MAP_HEIGHT)) u_y (
        .clk(clk), .arst_n(arst_n), .en(write_s & co_last_s & x_last_s), .clr(start_acc_s),
        .cnt(y_s), .last(y_last_s)
    );

    // Control FSM; every output is registered from the state being entered.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r        <= IDLE;
            running_r      <= 1'b0;
            ready_r        <= 1'b0;
            output_valid_r <= 1'b0;
            acc_clear_r    <= 1'b0;
            done_r         <= 1'b0;
            output_x_r     <= '0;
            output_y_r     <= '0;
            output_ch_r    <= '0;
        end else begin
            output_valid_r <= 1'b0;
            acc_clear_r    <= 1'b0;
            done_r         <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                        ready_r   <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                        ready_r   <= 1'b0;
                    end
                end
                RUN: begin
                    if (mac_en_s && beat_last_s) begin
                        state_r        <= WRITE;
                        ready_r        <= 1'b0;
                        output_valid_r <= 1'b1;
                        acc_clear_r    <= 1'b1;
                        done_r         <= layer_last_s;
                        output_x_r     <= x_s;
                        output_y_r     <= y_s;
                        output_ch_r    <= co_s;
                    end else begin
                        state_r <= RUN;
                        ready_r <= 1'b1;
                    end
                end
                WRITE: begin
                    if (layer_last_s) begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                        ready_r   <= 1'b0;
                    end else begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                        ready_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONV_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles_r;

    assign stall_cycles = stall_cycles_r;

    // Stall accounting: RUN cycles without an input beat, saturating, frozen once the layer ends.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cycles_r <= 32'd0;
        end else if (start_acc_s) begin
            stall_cycles_r <= 32'd0;
        end else if ((state_r == RUN) && !valid && (stall_cycles_r != 32'hFFFF_FFFF)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end
`endif

endmodule

// File: tb/tb_conv_loop_controller.sv
// Self-checking bench for conv_loop_controller with randomized valid and a nested-loop reference.
`timescale 1ns/1ps
module tb_conv_loop_controller;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int CI    = 2;
    localparam int CO    = 2;
    localparam int K     = 3;
    localparam int BEATS = K * K * CI;
    localparam int NOUT  = W * H * CO;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       start;
    logic       valid;
    logic       running;
    logic       ready;
    logic       mac_en;
    logic       acc_clear;
    logic       output_valid;
    logic [1:0] output_x;
    logic [1:0] output_y;
    logic [0:0] output_ch;
    logic       done;
`ifdef CONV_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int exp_x[$];
    int exp_y[$];
    int exp_ch[$];

    always #5 clk = ~clk;

    conv_loop_controller #(
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS(CI), .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(K)
    ) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .running(running),
        .valid(valid), .ready(ready), .mac_en(mac_en), .acc_clear(acc_clear),
        .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
        .output_ch(output_ch), .done(done)
`ifdef CONV_CTRL_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One layer: start pulse, then drive valid each cycle and check every strobe against the reference.
    task automatic run_layer(input int pct, input bit fixed_timing, input int poke_at,
                             input int stop_after, input int stall_from, input int stall_len,
                             input int exp_stall);
        int idx = 0;
        int beats = 0;
        int total = 0;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("running_up", running, 1);
`ifdef CONV_CTRL_STALL_CNT_EN
        check("stall_clear", stall_cycles, 0);
`endif
        while (idx < stop_after && cyc < 4000) begin
            if (output_valid) begin
                check("beats_per_out", beats, BEATS);
                check("out_x", output_x, exp_x[idx]);
                check("out_y", output_y, exp_y[idx]);
                check("out_ch", output_ch, exp_ch[idx]);
                check("acc_clear", acc_clear, 1);
                check("done", done, (idx == NOUT - 1) ? 1 : 0);
                if (fixed_timing) check("strobe_cycle", cyc, (BEATS + 1) * (idx + 1));
                beats = 0;
                idx++;
            end else begin
                check("no_clear", acc_clear, 0);
            end
            start = (cyc == poke_at);
            if (cyc >= stall_from && cyc < stall_from + stall_len) valid = 1'b0;
            else valid = ($urandom_range(99) < pct);
            #1;
            if (mac_en) begin
                beats++;
                total++;
            end
            if (!valid) check("mac_en_gate", mac_en, 0);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        valid = 1'b0;
        check("strobe_count", idx, stop_after);
        if (stop_after == NOUT) begin
            check("total_beats", total, NOUT * BEATS);
            check("running_down", running, 0);
`ifdef CONV_CTRL_STALL_CNT_EN
            if (exp_stall >= 0) check("stall_cycles", stall_cycles, exp_stall);
`endif
        end
    endtask

    initial begin
        int strobes;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int c = 0; c < CO; c++) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                    exp_ch.push_back(c);
                end

        arst_n = 1'b0;
        start  = 1'b0;
        valid  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_running", running, 0);
        check("rst_ready", ready, 0);
        check("rst_ovalid", output_valid, 0);
        check("rst_done", done, 0);
        check("rst_coords", {output_x, output_y, output_ch}, 0);
        arst_n = 1'b1;
        @(negedge clk);
        check("idle_running", running, 0);

        run_layer(100, 1'b1, -1, NOUT, -1, 0, 0);
        run_layer(50, 1'b0, -1, NOUT, -1, 0, -1);
        run_layer(100, 1'b1, 100, NOUT, -1, 0, 0);

        run_layer(50, 1'b0, -1, 5, -1, 0, -1);
        arst_n = 1'b0;
        #1;
        check("abort_running", running, 0);
        check("abort_ready", ready, 0);
        check("abort_ovalid", output_valid, 0);
        check("abort_done", done, 0);
        check("abort_coords", {output_x, output_y, output_ch}, 0);
        @(negedge clk);
        arst_n = 1'b1;
        valid  = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (output_valid || running) strobes++;
        end
        valid = 1'b0;
        check("post_abort_quiet", strobes, 0);
        run_layer(100, 1'b1, -1, NOUT, -1, 0, 0);

`ifdef CONV_CTRL_STALL_CNT_EN
        run_layer(100, 1'b0, -1, NOUT, 2, 7, 7);
        repeat (5) @(negedge clk);
        check("stall_hold", stall_cycles, 7);
        run_layer(100, 1'b1, -1, NOUT, -1, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
